// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: pipeline side (drives register/stage status, consumes controls).
// slave:  hazard controller (consumes status, drives controls and counters).
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 16
);
  // ID-stage operand sources
  logic [3:0]       ID_Pa;
  logic [3:0]       ID_Pb;
  logic [3:0]       ID_Pd;
  logic             ID_use_a;
  logic             ID_use_b;
  logic             ID_use_d;

  // Downstream destinations
  logic [3:0]       EX_Rd;
  logic             EX_RF_enable;
  logic             EX_load_instr;
  logic [3:0]       MEM_Rd;
  logic             MEM_RF_enable;
  logic [3:0]       WB_Rd;
  logic             WB_RF_enable;

  // Events
  logic             branch_taken;
  logic             mem_busy;

  // Pipeline register controls
  logic             PC_load;
  logic             IF_ID_load;
  logic             IF_ID_flush;
  logic             ID_EX_nop;
  logic             pipe_freeze;

  // Forwarding selects: 00 regfile, 01 EX, 10 MEM, 11 WB
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       fwd_d;

  // Status
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_Pa, ID_Pb, ID_Pd, ID_use_a, ID_use_b, ID_use_d,
    output EX_Rd, EX_RF_enable, EX_load_instr,
    output MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable,
    output branch_taken, mem_busy,
    input  PC_load, IF_ID_load, IF_ID_flush, ID_EX_nop, pipe_freeze,
    input  fwd_a, fwd_b, fwd_d,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_Pa, ID_Pb, ID_Pd, ID_use_a, ID_use_b, ID_use_d,
    input  EX_Rd, EX_RF_enable, EX_load_instr,
    input  MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable,
    input  branch_taken, mem_busy,
    output PC_load, IF_ID_load, IF_ID_flush, ID_EX_nop, pipe_freeze,
    output fwd_a, fwd_b, fwd_d,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard and sequencing controller for the 5-stage pipeline.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; handles flush, load-use stall, freeze entry
//   MEM_WAIT | data memory busy; EX/MEM and MEM/WB frozen, wait timer runs
//   TIMEOUT  | memory never answered; pipeline frozen until reset
//
// Control outputs depend on the current state and this cycle's inputs so a
// memory stall or a branch takes effect in the same cycle it is reported.
// R15 is supplied by the PC path, so it never forwards and never stalls.
module hazard_ctrl_unit #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_unit_if.slave hz
);

  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t           state;
  logic             pending_flush;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout_q;

  logic             load_use;
  logic             run_rules;
  logic             freeze;
  logic             do_flush;
  logic             do_stall;

  logic             pc_load;
  logic             if_id_load;
  logic             if_id_flush;
  logic             id_ex_nop;
  logic             pipe_freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       fwd_d;

  // Youngest producer wins; the use bit only qualifies the EX match.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       src_used,
    input logic [3:0] ex_rd,
    input logic       ex_en,
    input logic [3:0] mem_rd,
    input logic       mem_en,
    input logic [3:0] wb_rd,
    input logic       wb_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src == 4'hF)
      sel = 2'b00;
    else if (src_used && ex_en && (ex_rd == src))
      sel = 2'b01;
    else if (mem_en && (mem_rd == src))
      sel = 2'b10;
    else if (wb_en && (wb_rd == src))
      sel = 2'b11;
    return sel;
  endfunction

  // Operand forwarding selects for the three ID-stage sources.
  always_comb begin
    fwd_a = fwd_sel(hz.ID_Pa, hz.ID_use_a, hz.EX_Rd, hz.EX_RF_enable,
                    hz.MEM_Rd, hz.MEM_RF_enable, hz.WB_Rd, hz.WB_RF_enable);
    fwd_b = fwd_sel(hz.ID_Pb, hz.ID_use_b, hz.EX_Rd, hz.EX_RF_enable,
                    hz.MEM_Rd, hz.MEM_RF_enable, hz.WB_Rd, hz.WB_RF_enable);
    fwd_d = fwd_sel(hz.ID_Pd, hz.ID_use_d, hz.EX_Rd, hz.EX_RF_enable,
                    hz.MEM_Rd, hz.MEM_RF_enable, hz.WB_Rd, hz.WB_RF_enable);
  end

  // A load in EX whose result a used ID source needs cannot be forwarded yet.
  always_comb begin
    load_use = 1'b0;
    if (hz.EX_load_instr && hz.EX_RF_enable) begin
      if (hz.ID_use_a && (hz.ID_Pa != 4'hF) && (hz.ID_Pa == hz.EX_Rd))
        load_use = 1'b1;
      if (hz.ID_use_b && (hz.ID_Pb != 4'hF) && (hz.ID_Pb == hz.EX_Rd))
        load_use = 1'b1;
      if (hz.ID_use_d && (hz.ID_Pd != 4'hF) && (hz.ID_Pd == hz.EX_Rd))
        load_use = 1'b1;
    end
  end

  // Decide which pipeline action applies this cycle. The MEM_WAIT exit cycle
  // behaves exactly like RUN so a branch held in frozen EX is serviced then.
  always_comb begin
    run_rules = !hz.mem_busy && ((state == RUN) || (state == MEM_WAIT));
    freeze    = hz.mem_busy && ((state == RUN) || (state == MEM_WAIT));
    do_flush  = run_rules && (hz.branch_taken || pending_flush);
    do_stall  = run_rules && !do_flush && load_use;
  end

  // Pipeline register controls; reset forces fetch to keep running.
  always_comb begin
    pc_load     = 1'b1;
    if_id_load  = 1'b1;
    if_id_flush = 1'b0;
    id_ex_nop   = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      pc_load    = 1'b1;
      if_id_load = 1'b1;
    end else if ((state == TIMEOUT) || freeze) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (do_flush) begin
      // IF/ID still loads, but it loads a NOP
      if_id_flush = 1'b1;
      id_ex_nop   = 1'b1;
    end else if (do_stall) begin
      pc_load    = 1'b0;
      if_id_load = 1'b0;
      id_ex_nop  = 1'b1;
    end
  end

  // FSM, wait timer, pending flush and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      wait_cnt      <= 8'd0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hz.mem_busy) begin
            wait_cnt <= 8'd1;
            if (hz.branch_taken)
              pending_flush <= 1'b1;
            if (MAX_WAIT_C <= 8'd1) begin
              state         <= TIMEOUT;
              mem_timeout_q <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (hz.mem_busy) begin
            // wait_cnt stays below MAX_WAIT here, so +1 cannot overflow
            wait_cnt <= wait_cnt + 8'd1;
            if ((wait_cnt + 8'd1) >= MAX_WAIT_C) begin
              state         <= TIMEOUT;
              mem_timeout_q <= 1'b1;
            end
          end else begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end
        end
        TIMEOUT: begin
          mem_timeout_q <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase

      if (do_flush) begin
        pending_flush <= 1'b0;
        if (flush_cnt != CNT_MAX)
          flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (do_stall) begin
        if (stall_cnt != CNT_MAX)
          stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.PC_load     = pc_load;
  assign hz.IF_ID_load  = if_id_load;
  assign hz.IF_ID_flush = if_id_flush;
  assign hz.ID_EX_nop   = id_ex_nop;
  assign hz.pipe_freeze = pipe_freeze;
  assign hz.fwd_a       = fwd_a;
  assign hz.fwd_b       = fwd_b;
  assign hz.fwd_d       = fwd_d;
  assign hz.mem_timeout = mem_timeout_q & ~reset;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit with MAX_WAIT=4 and CNT_W=4. Each cycle the
// expected output vector is queued when stimulus is applied and popped
// at the following falling edge for comparison.
module tb_hazard_ctrl_unit;

  logic clk;
  logic reset;

  hazard_ctrl_unit_if #(.CNT_W(4)) hz();

  hazard_ctrl_unit #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pa;
    logic [3:0] pb;
    logic [3:0] pd;
    logic [2:0] use_abd;
    logic [3:0] ex_rd;
    logic       ex_en;
    logic       ex_ld;
    logic [3:0] mem_rd;
    logic       mem_en;
    logic [3:0] wb_rd;
    logic       wb_en;
    logic       br;
    logic       busy;
  } in_t;

  localparam in_t IDLE = '0;

  // control field order: PC_load IF_ID_load IF_ID_flush ID_EX_nop pipe_freeze mem_timeout
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] FLUSH = 6'b111100;
  localparam logic [5:0] FRZ   = 6'b000010;
  localparam logic [5:0] TOUT  = 6'b000011;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  assign obs = {hz.PC_load, hz.IF_ID_load, hz.IF_ID_flush, hz.ID_EX_nop,
                hz.pipe_freeze, hz.mem_timeout, hz.fwd_a, hz.fwd_b, hz.fwd_d,
                hz.stall_cnt, hz.flush_cnt};

  function automatic logic [19:0] mk(input logic [5:0] c, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [1:0] fd,
                                     input logic [3:0] sc, input logic [3:0] fc);
    return {c, fa, fb, fd, sc, fc};
  endfunction

  function automatic in_t si(input logic [3:0] pa, input logic [3:0] pb,
                             input logic [3:0] pd, input logic [2:0] u,
                             input logic [3:0] exrd, input logic exen, input logic exld,
                             input logic [3:0] memrd, input logic memen,
                             input logic [3:0] wbrd, input logic wben,
                             input logic br, input logic busy);
    in_t s;
    s = '{pa, pb, pd, u, exrd, exen, exld, memrd, memen, wbrd, wben, br, busy};
    return s;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic apply(input in_t s, input logic rst, input logic [19:0] e);
    @(posedge clk);
    #1;
    reset            = rst;
    hz.ID_Pa         = s.pa;
    hz.ID_Pb         = s.pb;
    hz.ID_Pd         = s.pd;
    hz.ID_use_a      = s.use_abd[2];
    hz.ID_use_b      = s.use_abd[1];
    hz.ID_use_d      = s.use_abd[0];
    hz.EX_Rd         = s.ex_rd;
    hz.EX_RF_enable  = s.ex_en;
    hz.EX_load_instr = s.ex_ld;
    hz.MEM_Rd        = s.mem_rd;
    hz.MEM_RF_enable = s.mem_en;
    hz.WB_Rd         = s.wb_rd;
    hz.WB_RF_enable  = s.wb_en;
    hz.branch_taken  = s.br;
    hz.mem_busy      = s.busy;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    in_t s;
    logic [19:0] got, want;
    s = IDLE; s.br = 1'b1; s.busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(s, 1'b1, mk(NORM, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0));
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset cyc%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    in_t st[6];
    logic [19:0] ex[6];
    logic [19:0] got, want;
    st[0] = si(4'd3, 4'd1, 4'd2, 3'b100, 4'd3, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    ex[0] = mk(STALL, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0);
    st[1] = si(4'd3, 4'd1, 4'd2, 3'b100, 4'd0, 0, 0, 4'd3, 1, 4'd0, 0, 0, 0);
    ex[1] = mk(NORM, 2'b10, 2'b00, 2'b00, 4'd1, 4'd0);
    st[2] = si(4'd15, 4'd1, 4'd2, 3'b100, 4'd15, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    ex[2] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0);
    st[3] = si(4'd0, 4'd4, 4'd2, 3'b000, 4'd4, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    ex[3] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0);
    st[4] = si(4'd0, 4'd1, 4'd6, 3'b001, 4'd6, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    ex[4] = mk(STALL, 2'b00, 2'b00, 2'b01, 4'd1, 4'd0);
    st[5] = IDLE;
    ex[5] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd2, 4'd0);
    for (int i = 0; i < 6; i++) begin
      apply(st[i], 1'b0, ex[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use cyc%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_forward();
    in_t st[5];
    logic [19:0] ex[5];
    logic [19:0] got, want;
    st[0] = si(4'd1, 4'd5, 4'd2, 3'b010, 4'd5, 1, 0, 4'd5, 1, 4'd5, 1, 0, 0);
    ex[0] = mk(NORM, 2'b00, 2'b01, 2'b00, 4'd2, 4'd0);
    st[1] = si(4'd1, 4'd5, 4'd2, 3'b010, 4'd5, 0, 0, 4'd5, 1, 4'd5, 1, 0, 0);
    ex[1] = mk(NORM, 2'b00, 2'b10, 2'b00, 4'd2, 4'd0);
    st[2] = si(4'd1, 4'd5, 4'd2, 3'b010, 4'd5, 0, 0, 4'd5, 0, 4'd5, 1, 0, 0);
    ex[2] = mk(NORM, 2'b00, 2'b11, 2'b00, 4'd2, 4'd0);
    st[3] = si(4'd1, 4'd15, 4'd2, 3'b010, 4'd15, 1, 0, 4'd15, 1, 4'd15, 1, 0, 0);
    ex[3] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd2, 4'd0);
    st[4] = si(4'd1, 4'd2, 4'd7, 3'b111, 4'd1, 1, 0, 4'd2, 1, 4'd7, 1, 0, 0);
    ex[4] = mk(NORM, 2'b01, 2'b10, 2'b11, 4'd2, 4'd0);
    for (int i = 0; i < 5; i++) begin
      apply(st[i], 1'b0, ex[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL forward cyc%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_branch_vs_load_use();
    in_t st[2];
    logic [19:0] ex[2];
    logic [19:0] got, want;
    st[0] = si(4'd3, 4'd1, 4'd2, 3'b100, 4'd3, 1, 1, 4'd0, 0, 4'd0, 0, 1, 0);
    ex[0] = mk(FLUSH, 2'b01, 2'b00, 2'b00, 4'd2, 4'd0);
    st[1] = IDLE;
    ex[1] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd2, 4'd1);
    for (int i = 0; i < 2; i++) begin
      apply(st[i], 1'b0, ex[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch_vs_load_use cyc%0d got %h want %h", i, got, want);
      end
    end
  endtask

  // Branch reported only in the first busy cycle; the flush must come from
  // the remembered pending flag on the exit cycle.
  task automatic test_branch_during_wait();
    in_t st[8];
    logic [19:0] ex[8];
    logic [19:0] got, want;
    for (int i = 0; i < 8; i++) st[i] = IDLE;
    st[0].br = 1'b1; st[0].busy = 1'b1;
    st[1].busy = 1'b1;
    st[2].busy = 1'b1;
    st[5].busy = 1'b1;
    ex[0] = mk(FRZ,   2'b00, 2'b00, 2'b00, 4'd2, 4'd1);
    ex[1] = mk(FRZ,   2'b00, 2'b00, 2'b00, 4'd2, 4'd1);
    ex[2] = mk(FRZ,   2'b00, 2'b00, 2'b00, 4'd2, 4'd1);
    ex[3] = mk(FLUSH, 2'b00, 2'b00, 2'b00, 4'd2, 4'd1);
    ex[4] = mk(NORM,  2'b00, 2'b00, 2'b00, 4'd2, 4'd2);
    ex[5] = mk(FRZ,   2'b00, 2'b00, 2'b00, 4'd2, 4'd2);
    ex[6] = mk(NORM,  2'b00, 2'b00, 2'b00, 4'd2, 4'd2);
    ex[7] = mk(NORM,  2'b00, 2'b00, 2'b00, 4'd2, 4'd2);
    for (int i = 0; i < 8; i++) begin
      apply(st[i], 1'b0, ex[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL branch_during_wait cyc%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_saturation();
    in_t s;
    logic [3:0] es;
    logic [19:0] got, want;
    es = 4'd2;
    s = si(4'd3, 4'd1, 4'd2, 3'b100, 4'd3, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      if (i == 20)
        apply(IDLE, 1'b0, mk(NORM, 2'b00, 2'b00, 2'b00, 4'd15, 4'd2));
      else
        apply(s, 1'b0, mk(STALL, 2'b01, 2'b00, 2'b00, es, 4'd2));
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL saturation cyc%0d got %h want %h", i, got, want);
      end
      if (es != 4'd15) es = es + 4'd1;
    end
  endtask

  task automatic test_timeout();
    in_t st[10];
    logic rs[10];
    logic [19:0] ex[10];
    logic [19:0] got, want;
    for (int i = 0; i < 10; i++) begin
      st[i] = IDLE;
      rs[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      st[i].busy = 1'b1;
      ex[i] = mk(FRZ, 2'b00, 2'b00, 2'b00, 4'd15, 4'd2);
    end
    ex[4] = mk(TOUT, 2'b00, 2'b00, 2'b00, 4'd15, 4'd2);
    st[5].br = 1'b1;
    ex[5] = mk(TOUT, 2'b00, 2'b00, 2'b00, 4'd15, 4'd2);
    rs[6] = 1'b1;
    ex[6] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd15, 4'd2);
    ex[7] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);
    st[8].busy = 1'b1;
    ex[8] = mk(FRZ,  2'b00, 2'b00, 2'b00, 4'd0, 4'd0);
    ex[9] = mk(NORM, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      apply(st[i], rs[i], ex[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout cyc%0d got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    hz.ID_Pa         = 4'd0;
    hz.ID_Pb         = 4'd0;
    hz.ID_Pd         = 4'd0;
    hz.ID_use_a      = 1'b0;
    hz.ID_use_b      = 1'b0;
    hz.ID_use_d      = 1'b0;
    hz.EX_Rd         = 4'd0;
    hz.EX_RF_enable  = 1'b0;
    hz.EX_load_instr = 1'b0;
    hz.MEM_Rd        = 4'd0;
    hz.MEM_RF_enable = 1'b0;
    hz.WB_Rd         = 4'd0;
    hz.WB_RF_enable  = 1'b0;
    hz.branch_taken  = 1'b0;
    hz.mem_busy      = 1'b0;

    test_reset();
    test_load_use();
    test_forward();
    test_branch_vs_load_use();
    test_branch_during_wait();
    test_saturation();
    test_timeout();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
